// File: rtl/inst_rom_loader.sv
// inst_rom_loader: byte-stream program loader and combinational instruction ROM for the CPU fetch port
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  input  logic        load_valid_i,
  input  logic [7:0]  load_byte_i,
  output logic        load_ready_o,
  output logic        load_done_o,
  output logic        load_err_o,
  output logic        cpu_rst_o
);
  typedef enum logic [1:0] {HDR, DATA, RUN, ERR} state_t;
  localparam logic [DEPTH_LOG2:0] max_n = {1'b1, {DEPTH_LOG2{1'b0}}};
  state_t state, state_nx;
  logic [1:0] bcnt;
  logic [23:0] asm_r;
  logic [DEPTH_LOG2-1:0] word_ptr;
  logic [DEPTH_LOG2:0] n;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic take, last, hdr_ok, ptr_last, hit;
  logic [31:0] word;
  logic [DEPTH_LOG2-1:0] idx;
  logic unused_bits;
  assign unused_bits = ^rom_addr_i[1:0];
  assign word = {asm_r, load_byte_i};
  assign last = bcnt == 2'd3;
  assign take = load_valid_i & load_ready_o;
  assign hdr_ok = word[31:DEPTH_LOG2+1] == '0 && word[DEPTH_LOG2:0] != '0 && word[DEPTH_LOG2:0] <= max_n;
  assign ptr_last = {1'b0, word_ptr} + (DEPTH_LOG2+1)'(1) == n;
  assign idx = rom_addr_i[DEPTH_LOG2+1:2];
  assign hit = state == RUN && rom_ce_i && rom_addr_i[31:DEPTH_LOG2+2] == '0 && {1'b0, idx} < n;
  assign load_ready_o = !rst && (state == HDR || state == DATA);
  assign load_done_o = state == RUN;
  assign load_err_o = state == ERR;
  assign cpu_rst_o = state != RUN;
  always_ff @(posedge clk)
    state <= rst ? HDR : state_nx;
  always_comb begin
    state_nx = state;
    if (take && last)
      state_nx = state == HDR ? (hdr_ok ? DATA : ERR) : (ptr_last ? RUN : DATA);
  end
  always_ff @(posedge clk)
    if (rst) begin
      bcnt <= '0;
      asm_r <= '0;
      word_ptr <= '0;
      n <= '0;
    end else if (take) begin
      bcnt <= bcnt + 2'd1;
      asm_r <= {asm_r[15:0], load_byte_i};
      if (last && state == HDR && hdr_ok) begin
        n <= word[DEPTH_LOG2:0];
        word_ptr <= '0;
      end
      if (last && state == DATA)
        word_ptr <= word_ptr + DEPTH_LOG2'(1);
    end
  always_ff @(posedge clk)
    if (!rst && take && last && state == DATA)
      mem[word_ptr] <= word;
  always_comb
    rom_data_o = hit ? mem[idx] : 32'h0;
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: image-level reference model plus directed load, gating, error and reset scenarios
module tb_inst_rom_loader;
  logic clk = 0, rst = 1, rom_ce = 1, load_valid = 0;
  logic [31:0] rom_addr = 0;
  logic [7:0] load_byte = 0;
  logic [31:0] rom_data;
  logic load_ready, load_done, load_err, cpu_rst;
  int checks = 0, failures = 0;
  bit chk_en = 0;
  int m_phase = 0, m_cnt = 0;
  int unsigned m_n = 0;
  logic [31:0] m_hdr = 0, m_w = 0;
  logic [31:0] m_mem [1024];
  inst_rom_loader #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data),
    .load_valid_i(load_valid), .load_byte_i(load_byte), .load_ready_o(load_ready),
    .load_done_o(load_done), .load_err_o(load_err), .cpu_rst_o(cpu_rst)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk)
    if (rst) begin
      m_phase = 0;
      m_cnt = 0;
      m_n = 0;
    end else if (m_phase == 0 && load_valid) begin
      if (m_cnt < 4) begin
        m_hdr = {m_hdr[23:0], load_byte};
        m_cnt++;
        if (m_cnt == 4) begin
          if (m_hdr == 0 || m_hdr > 1024) m_phase = 2;
          else m_n = m_hdr;
        end
      end else begin
        m_w = {m_w[23:0], load_byte};
        if ((m_cnt - 4) % 4 == 3) m_mem[(m_cnt - 4) / 4] = m_w;
        m_cnt++;
        if (m_cnt == 4 + 4 * m_n) m_phase = 1;
      end
    end
  always @(negedge clk)
    if (chk_en) begin
      logic [31:0] exp_data;
      exp_data = 0;
      if (m_phase == 1 && rom_ce && (rom_addr >> 2) < m_n) exp_data = m_mem[rom_addr >> 2];
      check("model_ready", {31'b0, load_ready}, {31'b0, !rst && m_phase == 0});
      check("model_done", {31'b0, load_done}, {31'b0, m_phase == 1});
      check("model_err", {31'b0, load_err}, {31'b0, m_phase == 2});
      check("model_cpu_rst", {31'b0, cpu_rst}, {31'b0, m_phase != 1});
      check("model_rom_data", rom_data, exp_data);
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    rst = 1;
    load_valid = 0;
    tick();
    rst = 0;
  endtask
  task automatic send(input logic [7:0] b);
    load_valid = 1;
    load_byte = b;
    tick();
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8]);
  endtask
  task automatic rd(input string name, input logic [31:0] a, input logic ce, input logic [31:0] exp);
    rom_addr = a;
    rom_ce = ce;
    @(negedge clk);
    check(name, rom_data, exp);
  endtask
  logic [7:0] img [16];
  logic [31:0] basic [4];
  initial begin
    basic = '{32'd3, 32'h34010001, 32'h34020002, 32'h00221820};
    for (int i = 0; i < 16; i++) img[i] = basic[i/4][8*(3 - i%4) +: 8];
    reset_dut();
    chk_en = 1;
    @(negedge clk);
    check("reset_ready", {31'b0, load_ready}, 32'd1);
    check("reset_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("reset_rom_data", rom_data, 32'h0);
    for (int i = 0; i < 16; i++) begin
      load_valid = 1;
      load_byte = img[i];
      if (i == 15) begin
        @(negedge clk);
        check("done_after_15", {31'b0, load_done}, 32'd0);
      end
      tick();
    end
    load_valid = 0;
    @(negedge clk);
    check("done_after_16", {31'b0, load_done}, 32'd1);
    check("cpu_rst_after_16", {31'b0, cpu_rst}, 32'd0);
    rd("basic_a0", 0, 1, 32'h34010001);
    rd("basic_a4", 4, 1, 32'h34020002);
    rd("basic_a8", 8, 1, 32'h00221820);
    rd("basic_a12", 12, 1, 32'h0);
    rd("gate_ce0", 0, 0, 32'h0);
    rd("gate_high", 32'h1000, 1, 32'h0);
    rd("gate_low_bits", 6, 1, 32'h34020002);
    for (int i = 0; i < 4; i++) send(8'hFF);
    load_valid = 0;
    rd("run_bytes_ignored", 0, 1, 32'h34010001);
    check("run_not_ready", {31'b0, load_ready}, 32'd0);
    rst = 1;
    @(negedge clk);
    check("rst_forces_ready0", {31'b0, load_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("run_rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("run_rst_rom_data", rom_data, 32'h0);
    rst = 0;
    tick();
    send_word(32'd2);
    send(8'h11);
    send(8'h11);
    load_valid = 0;
    rst = 1;
    tick();
    @(negedge clk);
    check("midload_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("midload_done", {31'b0, load_done}, 32'd0);
    check("midload_err", {31'b0, load_err}, 32'd0);
    rst = 0;
    @(negedge clk);
    check("midload_ready", {31'b0, load_ready}, 32'd1);
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    load_valid = 0;
    rd("fresh_a0", 0, 1, 32'hDEADBEEF);
    rd("fresh_a4", 4, 1, 32'h0);
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      send(img[i]);
      load_valid = 0;
      if (i < 15) begin
        @(negedge clk);
        check("gap_ready", {31'b0, load_ready}, 32'd1);
      end
      tick();
    end
    rd("gap_a0", 0, 1, 32'h34010001);
    rd("gap_a4", 4, 1, 32'h34020002);
    rd("gap_a8", 8, 1, 32'h00221820);
    rd("gap_a12", 12, 1, 32'h0);
    reset_dut();
    send_word(32'h0);
    send(8'hAA);
    send(8'hBB);
    load_valid = 0;
    @(negedge clk);
    check("n0_err", {31'b0, load_err}, 32'd1);
    check("n0_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("n0_ready", {31'b0, load_ready}, 32'd0);
    check("n0_done", {31'b0, load_done}, 32'd0);
    reset_dut();
    send_word(32'h00000401);
    load_valid = 0;
    @(negedge clk);
    check("n401_err", {31'b0, load_err}, 32'd1);
    reset_dut();
    send_word(32'h80000001);
    load_valid = 0;
    @(negedge clk);
    check("nhigh_err", {31'b0, load_err}, 32'd1);
    reset_dut();
    send_word(32'h00000400);
    @(negedge clk);
    check("n1024_no_err", {31'b0, load_err}, 32'd0);
    for (int i = 0; i < 1024; i++) send_word(32'hA5000000 | i);
    load_valid = 0;
    @(negedge clk);
    check("n1024_done", {31'b0, load_done}, 32'd1);
    rd("n1024_last", 32'hFFC, 1, 32'hA50003FF);
    rd("n1024_first", 0, 1, 32'hA5000000);
    rd("n1024_beyond", 32'h1000, 1, 32'h0);
    reset_dut();
    @(negedge clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
